issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_if.sv | 58 +++++
 rtl/issue_ctrl.sv | 88 ++++++++
 tb/tb_issue_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/issue_ctrl_if.sv
// Shared decode/issue types and the issue controller's bus interface.
// The controller takes the slave modport; the decode/writeback side takes master.
package issue_pkg;
  typedef logic [4:0] reg_t;

  typedef enum logic [1:0] {
    alu_op_nope = 2'd0,
    alu_op_add  = 2'd1,
    alu_op_move = 2'd2
  } alu_op_t;

  typedef enum logic {
    font_reg = 1'b0,
    font_imm = 1'b1
  } font_t;

  typedef enum logic [1:0] {
    decoder_nope = 2'd0,
    decoder_keep = 2'd1,
    decoder_next = 2'd2
  } decoder_state_t;

  typedef struct packed {
    logic        pc_branch;
    font_t       alu_s1_font;
    alu_op_t     alu_opcode;
    logic        wb_wr;
    reg_t        reg_s1;
    reg_t        reg_s2;
    reg_t        reg_dst;
    logic [15:0] imm;
  } decoded_instruction_t;
endpackage

interface issue_ctrl_if #(parameter int REG_BITS = 5);
  import issue_pkg::*;

  logic                 dec_valid;
  decoded_instruction_t dec_instr;
  logic                 dec_ready;
  decoder_state_t       fetch_state;
  logic                 issue_valid;
  decoded_instruction_t issue_instr;
  logic                 wb_valid;
  logic [REG_BITS-1:0]  wb_reg;
  logic                 br_resolve;
  logic                 wb_err;

  modport master (
    output dec_valid, dec_instr, wb_valid, wb_reg, br_resolve,
    input  dec_ready, fetch_state, issue_valid, issue_instr, wb_err
  );

  modport slave (
    input  dec_valid, dec_instr, wb_valid, wb_reg, br_resolve,
    output dec_ready, fetch_state, issue_valid, issue_instr, wb_err
  );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue controller: register scoreboard, inflight write limit,
// and a branch hold that stalls decode until the branch resolves.
//
// state   | meaning
// RUN     | issuing normally, subject to scoreboard/inflight hazards
// BR_WAIT | branch issued, decode stalled until br_resolve
module issue_ctrl
  import issue_pkg::*;
#(
  parameter int REG_BITS     = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input logic         clk,
  input logic         rst,
  issue_ctrl_if.slave bus
);
  localparam int NREG = 1 << REG_BITS;
  localparam int IW   = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic {RUN, BR_WAIT} state_t;

  state_t               state;
  logic [NREG-1:0]      pend, pend_eff, pend_nxt;
  logic [IW-1:0]        inflight, inflight_eff, inflight_nxt;
  logic                 issue_valid_q, wb_err_q;
  decoded_instruction_t issue_instr_q;

  logic           wb_hit, s1_used, s2_used, dst_used, hazard, ready, accept;
  decoder_state_t fetch;

  always_comb begin
    wb_hit = bus.wb_valid && pend[bus.wb_reg];
    // A same-cycle writeback already counts as retired for the hazard check.
    pend_eff = pend;
    if (wb_hit) pend_eff[bus.wb_reg] = 1'b0;
    inflight_eff = inflight - IW'(wb_hit);

    s1_used  = (bus.dec_instr.alu_opcode != alu_op_nope) &&
               (bus.dec_instr.alu_s1_font == font_reg);
    s2_used  = (bus.dec_instr.alu_opcode == alu_op_add);
    dst_used = bus.dec_instr.wb_wr;

    hazard = (s1_used  && pend_eff[bus.dec_instr.reg_s1])  ||
             (s2_used  && pend_eff[bus.dec_instr.reg_s2])  ||
             (dst_used && pend_eff[bus.dec_instr.reg_dst]) ||
             (dst_used && (inflight_eff == IW'(MAX_INFLIGHT)));

    ready  = !rst && (state == RUN) && !hazard;
    accept = bus.dec_valid && ready;

    // Set after clear so a new owner of the same register wins.
    pend_nxt = pend_eff;
    if (accept && dst_used) pend_nxt[bus.dec_instr.reg_dst] = 1'b1;
    inflight_nxt = inflight_eff + IW'(accept && dst_used);

    if (!bus.dec_valid) fetch = decoder_nope;
    else if (ready)     fetch = decoder_next;
    else                fetch = decoder_keep;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      pend          <= '0;
      inflight      <= '0;
      issue_valid_q <= 1'b0;
      issue_instr_q <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      pend          <= pend_nxt;
      inflight      <= inflight_nxt;
      issue_valid_q <= accept;
      if (accept) issue_instr_q <= bus.dec_instr;
      if (bus.wb_valid && !pend[bus.wb_reg]) wb_err_q <= 1'b1;
      case (state)
        RUN:     if (accept && bus.dec_instr.pc_branch) state <= BR_WAIT;
        BR_WAIT: if (bus.br_resolve) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.dec_ready   = ready;
  assign bus.fetch_state = fetch;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_instr = issue_instr_q;
  assign bus.wb_err      = wb_err_q;
endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: RAW stall, inflight limit, branch hold,
// set/clear collision, bad writeback and reset mid-branch.
module tb_issue_ctrl;
  import issue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  issue_ctrl_if #(.REG_BITS(5)) bus ();

  issue_ctrl #(.REG_BITS(5), .MAX_INFLIGHT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic decoded_instruction_t mk(input alu_op_t op, input font_t f, input logic wb,
                                              input reg_t d, input reg_t s1, input reg_t s2,
                                              input logic br, input logic [15:0] imm);
    decoded_instruction_t i;
    i.pc_branch   = br;
    i.alu_s1_font = f;
    i.alu_opcode  = op;
    i.wb_wr       = wb;
    i.reg_s1      = s1;
    i.reg_s2      = s2;
    i.reg_dst     = d;
    i.imm         = imm;
    return i;
  endfunction

  function automatic decoded_instruction_t add_i(input reg_t d, input reg_t a, input reg_t b);
    return mk(alu_op_add, font_reg, 1'b1, d, a, b, 1'b0, 16'h0);
  endfunction
  function automatic decoded_instruction_t mov_r(input reg_t d, input reg_t s);
    return mk(alu_op_move, font_reg, 1'b1, d, s, 5'd0, 1'b0, 16'h0);
  endfunction
  // s1 carries a deliberately pending register to prove it is ignored for immediates.
  function automatic decoded_instruction_t mov_i(input reg_t d, input reg_t s1, input logic [15:0] imm);
    return mk(alu_op_move, font_imm, 1'b1, d, s1, s1, 1'b0, imm);
  endfunction
  function automatic decoded_instruction_t nop_i(input logic br);
    return mk(alu_op_nope, font_reg, 1'b0, 5'd0, 5'd0, 5'd0, br, 16'h00aa);
  endfunction

  task automatic drive(input logic v, input decoded_instruction_t ins, input logic wv,
                       input reg_t wr, input logic br);
    bus.dec_valid  = v;
    bus.dec_instr  = ins;
    bus.wb_valid   = wv;
    bus.wb_reg     = wr;
    bus.br_resolve = br;
    #1;
  endtask

  task automatic chk_ready(input string tag, input logic exp_rdy);
    chk({tag, "_rdy"}, 64'(bus.dec_ready), 64'(exp_rdy));
    chk({tag, "_fs"}, 64'(bus.fetch_state),
        64'(exp_rdy ? decoder_next : decoder_keep));
  endtask

  decoded_instruction_t ins;

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
    chk("rst_issue_instr", 64'(bus.issue_instr), 64'd0);
    chk("rst_wb_err", 64'(bus.wb_err), 64'd0);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 5'd0, 1'b0);
    chk("idle_fs_nope", 64'(bus.fetch_state), 64'(decoder_nope));

    // RAW: add r3<-r1+r2, then move r4<-r3 waits for r3 writeback
    ins = add_i(5'd3, 5'd1, 5'd2);
    drive(1'b1, ins, 1'b0, 5'd0, 1'b0);
    chk_ready("raw_add", 1'b1);
    tick();
    chk("raw_add_iv", 64'(bus.issue_valid), 64'd1);
    chk("raw_add_ii", 64'(bus.issue_instr), 64'(ins));
    ins = mov_r(5'd4, 5'd3);
    drive(1'b1, ins, 1'b0, 5'd0, 1'b0);
    chk_ready("raw_stall0", 1'b0);
    tick();
    chk("raw_stall_iv", 64'(bus.issue_valid), 64'd0);
    chk_ready("raw_stall1", 1'b0);
    tick();
    drive(1'b1, ins, 1'b1, 5'd3, 1'b0);
    chk_ready("raw_bypass", 1'b1);
    tick();
    chk("raw_mov_iv", 64'(bus.issue_valid), 64'd1);
    chk("raw_mov_ii", 64'(bus.issue_instr), 64'(ins));
    drive(1'b0, ins, 1'b1, 5'd4, 1'b0);
    tick();
    chk("raw_iv_drop", 64'(bus.issue_valid), 64'd0);
    chk("raw_no_err", 64'(bus.wb_err), 64'd0);

    // Inflight limit: r1..r4 outstanding, r5 waits for a writeback
    for (int r = 1; r <= 4; r++) begin
      drive(1'b1, mov_i(reg_t'(r), 5'd0, 16'(r)), 1'b0, 5'd0, 1'b0);
      chk_ready($sformatf("full_fill%0d", r), 1'b1);
      tick();
    end
    ins = mov_i(5'd5, 5'd0, 16'h55);
    drive(1'b1, ins, 1'b0, 5'd0, 1'b0);
    chk_ready("full_stall", 1'b0);
    tick();
    drive(1'b1, ins, 1'b1, 5'd1, 1'b0);
    chk_ready("full_bypass", 1'b1);
    tick();
    chk("full_ii", 64'(bus.issue_instr), 64'(ins));
    drive(1'b1, mov_i(5'd6, 5'd0, 16'h66), 1'b0, 5'd0, 1'b0);
    chk_ready("full_still4", 1'b0);
    drive(1'b1, nop_i(1'b0), 1'b0, 5'd0, 1'b0);
    chk_ready("full_nop", 1'b1);
    tick();
    for (int r = 2; r <= 5; r++) begin
      drive(1'b0, '0, 1'b1, reg_t'(r), 1'b0);
      tick();
    end
    chk("full_drain_err", 64'(bus.wb_err), 64'd0);

    // Branch hold
    ins = nop_i(1'b1);
    drive(1'b1, ins, 1'b0, 5'd0, 1'b0);
    chk_ready("br_accept", 1'b1);
    tick();
    drive(1'b1, nop_i(1'b0), 1'b0, 5'd0, 1'b0);
    chk_ready("br_wait0", 1'b0);
    tick();
    drive(1'b1, nop_i(1'b0), 1'b0, 5'd0, 1'b1);
    chk_ready("br_resolve_cyc", 1'b0);
    tick();
    drive(1'b1, nop_i(1'b0), 1'b0, 5'd0, 1'b0);
    chk_ready("br_after", 1'b1);
    tick();

    // Set/clear collision on r7
    drive(1'b1, mov_i(5'd7, 5'd0, 16'h7), 1'b0, 5'd0, 1'b0);
    chk_ready("col_first", 1'b1);
    tick();
    drive(1'b1, mov_i(5'd7, 5'd0, 16'h77), 1'b1, 5'd7, 1'b0);
    chk_ready("col_same", 1'b1);
    tick();
    chk("col_no_err", 64'(bus.wb_err), 64'd0);
    drive(1'b1, mov_r(5'd8, 5'd7), 1'b0, 5'd0, 1'b0);
    chk_ready("col_pend7", 1'b0);
    for (int r = 10; r <= 12; r++) begin
      drive(1'b1, mov_i(reg_t'(r), 5'd7, 16'(r)), 1'b0, 5'd0, 1'b0);
      chk_ready($sformatf("col_fill%0d", r), 1'b1);
      tick();
    end
    drive(1'b1, mov_i(5'd13, 5'd0, 16'hd), 1'b0, 5'd0, 1'b0);
    chk_ready("col_inflight4", 1'b0);
    drive(1'b0, '0, 1'b1, 5'd7, 1'b0);
    tick();
    for (int r = 10; r <= 12; r++) begin
      drive(1'b0, '0, 1'b1, reg_t'(r), 1'b0);
      tick();
    end
    chk("col_drain_err", 64'(bus.wb_err), 64'd0);

    // Bad writeback, then reset mid-branch with r2 pending
    drive(1'b0, '0, 1'b1, 5'd9, 1'b0);
    tick();
    chk("bad_wb_err", 64'(bus.wb_err), 64'd1);
    drive(1'b0, '0, 1'b0, 5'd0, 1'b0);
    tick();
    chk("bad_wb_sticky", 64'(bus.wb_err), 64'd1);
    drive(1'b1, mov_i(5'd2, 5'd0, 16'h2), 1'b0, 5'd0, 1'b0);
    chk_ready("rb_mov_r2", 1'b1);
    tick();
    drive(1'b1, nop_i(1'b1), 1'b0, 5'd0, 1'b0);
    chk_ready("rb_branch", 1'b1);
    tick();
    ins = mov_r(5'd5, 5'd2);
    drive(1'b1, ins, 1'b0, 5'd0, 1'b0);
    chk_ready("rb_pre_rst", 1'b0);
    rst = 1'b1;
    drive(1'b1, ins, 1'b1, 5'd2, 1'b0);
    tick();
    chk("rb_iv", 64'(bus.issue_valid), 64'd0);
    chk("rb_ii", 64'(bus.issue_instr), 64'd0);
    chk("rb_err", 64'(bus.wb_err), 64'd0);
    rst = 1'b0;
    drive(1'b1, ins, 1'b0, 5'd0, 1'b0);
    chk_ready("rb_post", 1'b1);
    tick();
    chk("rb_post_iv", 64'(bus.issue_valid), 64'd1);
    chk("rb_post_ii", 64'(bus.issue_instr), 64'(ins));
    drive(1'b0, '0, 1'b0, 5'd0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
